irq_timer_unit: RTL and testbench



---
 rtl/irq_timer_unit.sv | 172 +++++++++++++++++
 tb/tb_irq_timer_unit.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_timer_unit.sv
// Machine-level interrupt source: 64-bit mtime/mtimecmp timer with prescaler,
// synchronized external (edge, latched) and UART (level) interrupt lines,
// and a single-cycle memory-mapped register port feeding the CSR excep vector.
module irq_timer_unit #(
   parameter int unsigned width       = 32,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned PRESCALE_W  = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             bus_sel,
   input  logic             bus_wr,
   input  logic [4:0]       bus_addr,
   input  logic [width-1:0] bus_wdata,
   output logic [width-1:0] bus_rdata,
   output logic             bus_rvalid,
   input  logic             ext_irq,
   input  logic             uart_irq,
   output logic [width-1:0] excep
);

   localparam int unsigned REG_W     = 32;
   localparam int unsigned IRQ_TIMER = 7;
   localparam int unsigned IRQ_EXT   = 11;
   localparam int unsigned IRQ_UART  = 16;

   localparam logic [2:0] ADDR_MTIME_LO    = 3'd0;
   localparam logic [2:0] ADDR_MTIME_HI    = 3'd1;
   localparam logic [2:0] ADDR_MTIMECMP_LO = 3'd2;
   localparam logic [2:0] ADDR_MTIMECMP_HI = 3'd3;
   localparam logic [2:0] ADDR_PRESCALE    = 3'd4;
   localparam logic [2:0] ADDR_EXT_PEND    = 3'd5;

   logic [63:0]            mtime;
   logic [63:0]            mtimecmp;
   logic [PRESCALE_W-1:0]  prescale;
   logic [PRESCALE_W-1:0]  pre_cnt;
   logic [SYNC_STAGES-1:0] ext_sync;
   logic [SYNC_STAGES-1:0] uart_sync;
   logic                   ext_last;
   logic                   ext_pend;

   logic                   tick_c;
   logic                   ext_rise_c;
   logic                   wr_c;
   logic                   rd_c;
   logic [2:0]             reg_idx;
   logic [REG_W-1:0]       wdata_c;
   logic [REG_W-1:0]       rdata_c;
   logic [width-1:0]       excep_c;
   logic                   unused_addr_bits;

   // Bus decode; the byte-offset bits inside a word carry no meaning here
   assign reg_idx          = bus_addr[4:2];
   assign wr_c             = bus_sel & bus_wr;
   assign rd_c             = bus_sel & ~bus_wr;
   assign wdata_c          = REG_W'(bus_wdata);
   assign unused_addr_bits = ^bus_addr[1:0];

   assign tick_c     = (pre_cnt == prescale);
   assign ext_rise_c = ext_sync[SYNC_STAGES-1] & ~ext_last;

   // Prescaler: counter wraps at the reload value and yields a tick on the wrap
   always_ff @(posedge clk) begin
      if (reset) begin
         prescale <= '0;
         pre_cnt  <= '0;
      end else if (wr_c && (reg_idx == ADDR_PRESCALE)) begin
         prescale <= wdata_c[PRESCALE_W-1:0];
         pre_cnt  <= '0;
      end else if (tick_c) begin
         pre_cnt  <= '0;
      end else begin
         pre_cnt  <= pre_cnt + PRESCALE_W'(1);
      end
   end

   // mtime: a software write to either half takes priority over the tick
   always_ff @(posedge clk) begin
      if (reset) begin
         mtime <= '0;
      end else if (wr_c && (reg_idx == ADDR_MTIME_LO)) begin
         mtime[31:0] <= wdata_c;
      end else if (wr_c && (reg_idx == ADDR_MTIME_HI)) begin
         mtime[63:32] <= wdata_c;
      end else if (tick_c) begin
         mtime <= mtime + 64'd1;
      end
   end

   // mtimecmp: plain RW halves, reset to the never-matching all-ones value
   always_ff @(posedge clk) begin
      if (reset) begin
         mtimecmp <= '1;
      end else if (wr_c && (reg_idx == ADDR_MTIMECMP_LO)) begin
         mtimecmp[31:0] <= wdata_c;
      end else if (wr_c && (reg_idx == ADDR_MTIMECMP_HI)) begin
         mtimecmp[63:32] <= wdata_c;
      end
   end

   // External line: synchronize, edge-detect, latch; a new edge beats a W1C clear
   always_ff @(posedge clk) begin
      if (reset) begin
         ext_sync <= '0;
         ext_last <= 1'b0;
         ext_pend <= 1'b0;
      end else begin
         ext_sync <= {ext_sync[SYNC_STAGES-2:0], ext_irq};
         ext_last <= ext_sync[SYNC_STAGES-1];
         if (ext_rise_c) begin
            ext_pend <= 1'b1;
         end else if (wr_c && (reg_idx == ADDR_EXT_PEND) && wdata_c[0]) begin
            ext_pend <= 1'b0;
         end
      end
   end

   // UART line: level-sensitive, synchronize only
   always_ff @(posedge clk) begin
      if (reset) begin
         uart_sync <= '0;
      end else begin
         uart_sync <= {uart_sync[SYNC_STAGES-2:0], uart_irq};
      end
   end

   // Read mux over the register map; unmapped words read zero
   always_comb begin
      rdata_c = '0;
      case (reg_idx)
         ADDR_MTIME_LO:    rdata_c = mtime[31:0];
         ADDR_MTIME_HI:    rdata_c = mtime[63:32];
         ADDR_MTIMECMP_LO: rdata_c = mtimecmp[31:0];
         ADDR_MTIMECMP_HI: rdata_c = mtimecmp[63:32];
         ADDR_PRESCALE:    rdata_c = REG_W'(prescale);
         ADDR_EXT_PEND:    rdata_c = {31'b0, ext_pend};
         default:          rdata_c = '0;
      endcase
   end

   // Read response: one-cycle valid pulse, data holds between reads
   always_ff @(posedge clk) begin
      if (reset) begin
         bus_rdata  <= '0;
         bus_rvalid <= 1'b0;
      end else begin
         bus_rvalid <= rd_c;
         if (rd_c) begin
            bus_rdata <= width'(rdata_c);
         end
      end
   end

   // Interrupt vector assembly from pre-edge state
   always_comb begin
      excep_c            = '0;
      excep_c[IRQ_TIMER] = (mtime >= mtimecmp);
      excep_c[IRQ_EXT]   = ext_pend;
      excep_c[IRQ_UART]  = uart_sync[SYNC_STAGES-1];
   end

   // Registered interrupt vector toward the CSR file
   always_ff @(posedge clk) begin
      if (reset) begin
         excep <= '0;
      end else begin
         excep <= excep_c;
      end
   end

endmodule

// File: tb/tb_irq_timer_unit.sv
// Directed bench for irq_timer_unit: read responses go through an expected-data
// queue; interrupt and register behaviour is checked at fixed cycle offsets.
module tb_irq_timer_unit;

   localparam logic [4:0] A_MTIME_LO    = 5'h00;
   localparam logic [4:0] A_MTIME_HI    = 5'h04;
   localparam logic [4:0] A_MTIMECMP_LO = 5'h08;
   localparam logic [4:0] A_MTIMECMP_HI = 5'h0C;
   localparam logic [4:0] A_PRESCALE    = 5'h10;
   localparam logic [4:0] A_EXT_PEND    = 5'h14;
   localparam logic [4:0] A_RSVD6       = 5'h18;
   localparam logic [4:0] A_RSVD7       = 5'h1C;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   logic        clk;
   logic        reset;
   logic        bus_sel;
   logic        bus_wr;
   logic [4:0]  bus_addr;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata;
   logic        bus_rvalid;
   logic        ext_irq;
   logic        uart_irq;
   logic [31:0] excep;

   int          checks = 0;
   int          errors = 0;
   exp_t        exp_q[$];
   logic [31:0] last_rdata = 32'd0;

   irq_timer_unit #(
      .width      (32),
      .SYNC_STAGES(2),
      .PRESCALE_W (16)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .bus_sel   (bus_sel),
      .bus_wr    (bus_wr),
      .bus_addr  (bus_addr),
      .bus_wdata (bus_wdata),
      .bus_rdata (bus_rdata),
      .bus_rvalid(bus_rvalid),
      .ext_irq   (ext_irq),
      .uart_irq  (uart_irq),
      .excep     (excep)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
         else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
         end
   endtask

   // One clock edge; outputs are sampled 1 time unit after it
   task automatic cycle();
      logic rst_pre;
      logic exp_rv;
      exp_t e;
      rst_pre = reset;
      exp_rv  = bus_sel && !bus_wr && !reset;
      @(posedge clk);
      #1;
      if (rst_pre) begin
         exp_q.delete();
         last_rdata = 32'd0;
      end
      check("rvalid", {31'b0, bus_rvalid}, {31'b0, exp_rv});
      if (exp_rv) begin
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check(e.tag, bus_rdata, e.val);
            last_rdata = e.val;
         end else begin
            check("scoreboard_empty", 32'(exp_q.size()), 32'd1);
         end
      end else begin
         check("rdata_hold", bus_rdata, last_rdata);
      end
   endtask

   task automatic bus_write(input logic [4:0] addr, input logic [31:0] data);
      bus_sel   = 1'b1;
      bus_wr    = 1'b1;
      bus_addr  = addr;
      bus_wdata = data;
      cycle();
      bus_sel   = 1'b0;
      bus_wr    = 1'b0;
   endtask

   task automatic bus_read(input logic [4:0] addr, input string tag, input logic [31:0] exp);
      exp_t e;
      e.tag = tag;
      e.val = exp;
      exp_q.push_back(e);
      bus_sel  = 1'b1;
      bus_wr   = 1'b0;
      bus_addr = addr;
      cycle();
      bus_sel  = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset     = 1'b1;
      bus_sel   = 1'b0;
      bus_wr    = 1'b0;
      bus_addr  = 5'd0;
      bus_wdata = 32'd0;
      ext_irq   = 1'b0;
      uart_irq  = 1'b0;

      // Reset and reset values
      cycle();
      cycle();
      check("reset_excep", excep, 32'd0);
      check("reset_rdata", bus_rdata, 32'd0);
      reset = 1'b0;
      bus_read(A_MTIMECMP_LO, "rst_mtimecmp_lo", 32'hFFFF_FFFF);
      cycle();
      bus_read(A_EXT_PEND, "rst_ext_pend", 32'd0);

      // Prescaled timer and compare
      bus_write(A_PRESCALE, 32'hABCD_0003);
      bus_write(A_MTIMECMP_LO, 32'd5);
      bus_write(A_MTIMECMP_HI, 32'd0);
      bus_write(A_MTIME_LO, 32'd0);
      bus_write(A_MTIME_HI, 32'd0);
      repeat (3) cycle();
      bus_read(A_MTIME_LO, "mtime_e4", 32'd0);
      bus_read(A_MTIME_LO, "mtime_e5", 32'd1);
      repeat (2) cycle();
      bus_read(A_MTIME_LO, "mtime_e8", 32'd1);
      bus_read(A_MTIME_LO, "mtime_e9", 32'd2);
      repeat (11) cycle();
      check("timer_before", {31'b0, excep[7]}, 32'd0);
      bus_read(A_MTIME_LO, "mtime_e21", 32'd5);
      check("timer_rise", {31'b0, excep[7]}, 32'd1);
      bus_read(A_MTIME_HI, "mtime_hi", 32'd0);
      bus_write(A_MTIMECMP_LO, 32'd100);
      check("timer_cmp_lag", {31'b0, excep[7]}, 32'd1);
      cycle();
      check("timer_clear", {31'b0, excep[7]}, 32'd0);
      bus_read(A_PRESCALE, "prescale_rd", 32'h0000_0003);
      bus_read(5'h0B, "cmp_lo_offset", 32'd100);
      bus_write(A_RSVD7, 32'hDEAD_BEEF);
      bus_read(A_RSVD6, "rsvd6", 32'd0);
      bus_read(A_RSVD7, "rsvd7", 32'd0);

      // 64-bit wrap
      bus_write(A_PRESCALE, 32'd0);
      bus_write(A_MTIME_LO, 32'hFFFF_FFFF);
      bus_write(A_MTIME_HI, 32'hFFFF_FFFF);
      bus_read(A_MTIME_HI, "wrap_pre_hi", 32'hFFFF_FFFF);
      bus_read(A_MTIME_LO, "wrap_lo", 32'd0);
      bus_read(A_MTIME_HI, "wrap_hi", 32'd0);
      bus_read(A_MTIME_LO, "wrap_lo_next", 32'd2);

      // UART level through the synchronizer
      #2 uart_irq = 1'b1;
      cycle();
      cycle();
      check("uart_rise_early", {31'b0, excep[16]}, 32'd0);
      cycle();
      check("uart_rise", {31'b0, excep[16]}, 32'd1);
      check("uart_ext_quiet", {31'b0, excep[11]}, 32'd0);
      repeat (7) cycle();
      #2 uart_irq = 1'b0;
      cycle();
      cycle();
      check("uart_fall_early", {31'b0, excep[16]}, 32'd1);
      cycle();
      check("uart_fall", {31'b0, excep[16]}, 32'd0);
      check("uart_ext_quiet2", {31'b0, excep[11]}, 32'd0);

      // External edge latch and W1C
      #2 ext_irq = 1'b1;
      cycle();
      #2 ext_irq = 1'b0;
      cycle();
      cycle();
      check("ext_early", {31'b0, excep[11]}, 32'd0);
      cycle();
      check("ext_rise", {31'b0, excep[11]}, 32'd1);
      repeat (5) cycle();
      check("ext_held", {31'b0, excep[11]}, 32'd1);
      bus_read(A_EXT_PEND, "ext_pend_set", 32'd1);
      bus_write(A_EXT_PEND, 32'd0);
      cycle();
      check("ext_w0_keeps", {31'b0, excep[11]}, 32'd1);
      bus_write(A_EXT_PEND, 32'd1);
      check("ext_w1c_lag", {31'b0, excep[11]}, 32'd1);
      cycle();
      check("ext_w1c", {31'b0, excep[11]}, 32'd0);
      bus_read(A_EXT_PEND, "ext_pend_clr", 32'd0);

      // W1C colliding with a new synchronized edge: set wins
      #2 ext_irq = 1'b1;
      cycle();
      #2 ext_irq = 1'b0;
      cycle();
      bus_write(A_EXT_PEND, 32'd1);
      check("ext_collide_lag", {31'b0, excep[11]}, 32'd0);
      bus_read(A_EXT_PEND, "ext_collide_pend", 32'd1);
      check("ext_collide", {31'b0, excep[11]}, 32'd1);

      // Reset with a read in flight and the timer interrupt asserted
      bus_write(A_MTIMECMP_HI, 32'd0);
      bus_write(A_MTIMECMP_LO, 32'd0);
      cycle();
      check("timer_cmp0", {31'b0, excep[7]}, 32'd1);
      reset    = 1'b1;
      bus_sel  = 1'b1;
      bus_wr   = 1'b0;
      bus_addr = A_MTIME_LO;
      cycle();
      check("midrst_excep", excep, 32'd0);
      reset   = 1'b0;
      bus_sel = 1'b0;
      bus_read(A_MTIME_LO, "midrst_mtime_lo", 32'd0);
      bus_read(A_MTIMECMP_HI, "midrst_cmp_hi", 32'hFFFF_FFFF);
      bus_read(A_EXT_PEND, "midrst_ext_pend", 32'd0);
      check("midrst_excep_after", excep, 32'd0);
      cycle();
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
